program_fetch_unit: RTL

PROGRAM_FETCH_UNIT -- requirements
Module: program_fetch_unit

---
 rtl/program_fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 64 ++++++
 rtl/program_fetch_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/program_fetch_pkg.sv
// Shared defaults and sizing helpers for the program fetch unit and its queue.
package program_fetch_pkg;

  localparam int PF_ADDR_W     = 16;
  localparam int PF_INS_W      = 32;
  localparam int PF_QDEPTH     = 4;
  localparam int PF_RESET_ADDR = 0;
  localparam int PF_PC_INC     = 1;

  // Pointer width for a power-of-two queue depth.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int PF_QPTR_W = ptr_w(PF_QDEPTH);

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; holds fetched {instruction, address} pairs.
module fetch_queue
  import program_fetch_pkg::*;
#(
  parameter int WIDTH = PF_INS_W + PF_ADDR_W,
  parameter int DEPTH = PF_QDEPTH,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [PW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];

  // A full queue still accepts a push when the head leaves on the same edge.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/program_fetch_unit.sv
// Instruction prefetcher: issues sequential reads, redirects on jump, and
// buffers returned instructions for decode in a small queue.
module program_fetch_unit
  import program_fetch_pkg::*;
#(
  parameter int ADDR_W     = PF_ADDR_W,
  parameter int INS_W      = PF_INS_W,
  parameter int QDEPTH     = PF_QDEPTH,
  parameter int RESET_ADDR = PF_RESET_ADDR,
  parameter int PC_INC     = PF_PC_INC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    jmp_en,
  input  logic [ADDR_W-1:0]       jmp_loc,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [INS_W-1:0]        mem_rdata,
  output logic                    ins_valid,
  input  logic                    ins_ready,
  output logic [INS_W-1:0]        ins,
  output logic [ADDR_W-1:0]       ins_addr,
  output logic [ptr_w(QDEPTH):0]  q_count
);

  localparam int EW = INS_W + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d, iaddr_q, iaddr_d;
  logic              infl_q, infl_d;
  logic              xfer, fetch_ok, q_empty, q_push;
  logic [EW-1:0]     q_head;

  assign ins_valid = reset && !q_empty && !jmp_en;
  assign xfer      = ins_valid && ins_ready;
  // Response of the pre-jump stream is dropped when a jump lands on it.
  assign q_push    = infl_q && reset && !jmp_en;
  assign {ins, ins_addr} = (reset && !q_empty) ? q_head : '0;

  always_comb begin
    fetch_ok  = (int'(q_count) + int'(infl_q) - int'(xfer)) < QDEPTH;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    pc_d      = pc_q;
    if (reset) begin
      if (jmp_en) begin
        mem_rd_en = 1'b1;
        mem_addr  = jmp_loc;
        pc_d      = jmp_loc + ADDR_W'(PC_INC);
      end else begin
        mem_addr = pc_q;
        if (fetch_ok) begin
          mem_rd_en = 1'b1;
          pc_d      = pc_q + ADDR_W'(PC_INC);
        end
      end
    end
    infl_d  = mem_rd_en;
    iaddr_d = mem_addr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q   <= ADDR_W'(RESET_ADDR);
      infl_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      infl_q <= infl_d;
    end
  end

  always_ff @(posedge clk) begin
    iaddr_q <= iaddr_d;
  end

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (reset),
    .flush (jmp_en),
    .push  (q_push),
    .wdata ({mem_rdata, iaddr_q}),
    .pop   (xfer),
    .rdata (q_head),
    .empty (q_empty),
    .count (q_count)
  );

endmodule
